// File: rtl/regfile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer_if
// Description : Instruction request and register-file control bundle between
//               an instruction source and the regfile_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             EXEC;
    logic [9:0]       INSTR;
    logic             ENW;
    logic [2:0]       WRA;
    logic             ENR0;
    logic [2:0]       RDA0;
    logic [2:0]       RDA1;
    logic [1:0]       BUS_SEL;
    logic [1:0]       ALU_OP;
    logic             ALU_LATCH;
    logic             BUSY;
    logic             DONE;
    logic             ILLEGAL;
    logic [CNT_W-1:0] INSTR_CNT;

    // Instruction source side
    modport master (
        output EXEC, INSTR,
        input  ENW, WRA, ENR0, RDA0, RDA1, BUS_SEL, ALU_OP, ALU_LATCH,
               BUSY, DONE, ILLEGAL, INSTR_CNT
    );

    // Sequencer side
    modport slave (
        input  EXEC, INSTR,
        output ENW, WRA, ENR0, RDA0, RDA1, BUS_SEL, ALU_OP, ALU_LATCH,
               BUSY, DONE, ILLEGAL, INSTR_CNT
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sequencer
// Description : Moore FSM (IDLE/T1/T2/FIN) that decodes one 10-bit instruction
//               at a time into register-file and ALU control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sequencer #(
    parameter int CNT_W = 8
) (
    input  wire logic          CLKb,
    input  wire logic          RST,
    regfile_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [3:0] c_OP_LOAD = 4'd0;
    localparam logic [3:0] c_OP_COPY = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;

    localparam logic [1:0] c_BUS_EXT = 2'b00;
    localparam logic [1:0] c_BUS_Q0  = 2'b01;
    localparam logic [1:0] c_BUS_ALU = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [9:0]       r_ir;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0] w_opcode;
    logic [2:0] w_rx;
    logic [2:0] w_ry;
    logic       w_is_alu;
    logic       w_legal;
    logic [1:0] w_alu_code;

    logic       w_enw;
    logic [2:0] w_wra;
    logic       w_enr0;
    logic [2:0] w_rda0;
    logic [2:0] w_rda1;
    logic [1:0] w_bus_sel;
    logic [1:0] w_alu_op;
    logic       w_alu_latch;
    logic       w_done;

    // Everything downstream decodes from the latched IR, never from INSTR
    assign w_opcode = r_ir[9:6];
    assign w_rx     = r_ir[5:3];
    assign w_ry     = r_ir[2:0];
    assign w_is_alu = (w_opcode == c_OP_ADD) || (w_opcode == c_OP_SUB) ||
                      (w_opcode == c_OP_XOR);
    assign w_legal  = (w_opcode == c_OP_LOAD) || (w_opcode == c_OP_COPY) ||
                      w_is_alu;

    // ALU function code for the three arithmetic opcodes, 00 otherwise
    always_comb begin
        w_alu_code = 2'b00;
        case (w_opcode)
            c_OP_SUB: w_alu_code = 2'b01;
            c_OP_XOR: w_alu_code = 2'b10;
            default:  w_alu_code = 2'b00;
        endcase
    end

    // State, IR, sticky illegal flag and completion counter
    always_ff @(posedge CLKb) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && bus.EXEC) begin
                r_ir      <= bus.INSTR;
                r_illegal <= 1'b0;
            end
            if (r_state == S_T1 && !w_legal) begin
                r_illegal <= 1'b1;
            end
            if (r_state == S_FIN && w_legal) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state and Moore control decode; reset masks the write/latch strobes
    always_comb begin
        w_next_state = r_state;
        w_enw        = 1'b0;
        w_wra        = 3'd0;
        w_enr0       = 1'b0;
        w_rda0       = 3'd0;
        w_rda1       = 3'd0;
        w_bus_sel    = c_BUS_EXT;
        w_alu_op     = 2'b00;
        w_alu_latch  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.EXEC) begin
                    w_next_state = S_T1;
                end
            end
            S_T1: begin
                w_next_state = S_FIN;
                if (w_opcode == c_OP_LOAD) begin
                    w_enw     = 1'b1;
                    w_wra     = w_rx;
                    w_bus_sel = c_BUS_EXT;
                end else if (w_opcode == c_OP_COPY) begin
                    w_enr0    = 1'b1;
                    w_rda0    = w_ry;
                    w_bus_sel = c_BUS_Q0;
                    w_enw     = 1'b1;
                    w_wra     = w_rx;
                end else if (w_is_alu) begin
                    w_enr0       = 1'b1;
                    w_rda0       = w_rx;
                    w_rda1       = w_ry;
                    w_alu_latch  = 1'b1;
                    w_alu_op     = w_alu_code;
                    w_next_state = S_T2;
                end
            end
            S_T2: begin
                w_next_state = S_FIN;
                w_enw        = 1'b1;
                w_wra        = w_rx;
                w_bus_sel    = c_BUS_ALU;
                w_alu_op     = w_alu_code;
            end
            S_FIN: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (RST) begin
            w_enw       = 1'b0;
            w_alu_latch = 1'b0;
        end
    end

    assign bus.ENW       = w_enw;
    assign bus.WRA       = w_wra;
    assign bus.ENR0      = w_enr0;
    assign bus.RDA0      = w_rda0;
    assign bus.RDA1      = w_rda1;
    assign bus.BUS_SEL   = w_bus_sel;
    assign bus.ALU_OP    = w_alu_op;
    assign bus.ALU_LATCH = w_alu_latch;
    assign bus.BUSY      = (r_state != S_IDLE);
    assign bus.DONE      = w_done;
    assign bus.ILLEGAL   = r_illegal;
    assign bus.INSTR_CNT = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Directed, table-driven bench for regfile_sequencer plus
//               hand-written sequences for EXEC hold, mid-instruction reset
//               and counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sequencer;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_sequencer_if #(.CNT_W(CNT_W)) bus ();

    regfile_sequencer #(.CNT_W(CNT_W)) dut (
        .CLKb (clk),
        .RST  (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       exec;
        logic [9:0] instr;
        logic       enw;
        logic [2:0] wra;
        logic       enr0;
        logic [2:0] rda0;
        logic [2:0] rda1;
        logic [1:0] bus_sel;
        logic [1:0] alu_op;
        logic       latch;
        logic       busy;
        logic       done;
        logic       ill;
        logic [7:0] cnt;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_load();
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h010;
        tick();
        bus.EXEC  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [26:0] act;
        logic [26:0] exp;
        int          enw_seen;
        checks = 0;
        errors = 0;
        rst       = 1'b1;
        bus.EXEC  = 1'b0;
        bus.INSTR = '0;

        // name, rst, exec, instr, enw, wra, enr0, rda0, rda1, bus, aluop, latch, busy, done, ill, cnt
        vecs[0]  = '{"reset",      1, 1, 10'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{"idle",       0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{"load_t1",    0, 1, 10'h010, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{"load_fin",   0, 0, 10'h3FF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
        vecs[4]  = '{"load_idle",  0, 0, 10'h3FF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[5]  = '{"add_t1",     0, 1, 10'h08D, 0, 0, 1, 1, 5, 0, 0, 1, 1, 0, 0, 1};
        vecs[6]  = '{"add_t2",     0, 0, 10'h000, 1, 1, 0, 0, 0, 2, 0, 0, 1, 0, 0, 1};
        vecs[7]  = '{"add_fin",    0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
        vecs[8]  = '{"add_idle",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        vecs[9]  = '{"copy_t1",    0, 1, 10'h073, 1, 6, 1, 3, 0, 1, 0, 0, 1, 0, 0, 2};
        vecs[10] = '{"copy_fin",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2};
        vecs[11] = '{"copy_idle",  0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
        vecs[12] = '{"sub_t1",     0, 1, 10'h0DB, 0, 0, 1, 3, 3, 0, 1, 1, 1, 0, 0, 3};
        vecs[13] = '{"sub_t2",     0, 0, 10'h000, 1, 3, 0, 0, 0, 2, 1, 0, 1, 0, 0, 3};
        vecs[14] = '{"sub_fin",    0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 3};
        vecs[15] = '{"sub_idle",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};
        vecs[16] = '{"xor_t1",     0, 1, 10'h138, 0, 0, 1, 7, 0, 0, 2, 1, 1, 0, 0, 4};
        vecs[17] = '{"xor_t2",     0, 0, 10'h000, 1, 7, 0, 0, 0, 2, 2, 0, 1, 0, 0, 4};
        vecs[18] = '{"xor_fin",    0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4};
        vecs[19] = '{"xor_idle",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
        vecs[20] = '{"ill_t1",     0, 1, 10'h3C0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5};
        vecs[21] = '{"ill_fin",    0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5};
        vecs[22] = '{"ill_idle",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5};
        vecs[23] = '{"ill_sticky", 0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5};
        vecs[24] = '{"clr_t1",     0, 1, 10'h010, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5};
        vecs[25] = '{"clr_fin",    0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5};
        vecs[26] = '{"clr_idle",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6};
        vecs[27] = '{"op5_t1",     0, 1, 10'h14A, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6};
        vecs[28] = '{"op5_fin",    0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6};
        vecs[29] = '{"op5_idle",   0, 0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6};

        // Table: drive, clock, compare all outputs after the edge
        for (int i = 0; i < NVEC; i++) begin
            rst       = vecs[i].rst;
            bus.EXEC  = vecs[i].exec;
            bus.INSTR = vecs[i].instr;
            tick();
            act = {bus.ENW, bus.WRA, bus.ENR0, bus.RDA0, bus.RDA1, bus.BUS_SEL,
                   bus.ALU_OP, bus.ALU_LATCH, bus.BUSY, bus.DONE, bus.ILLEGAL,
                   bus.INSTR_CNT};
            exp = {vecs[i].enw, vecs[i].wra, vecs[i].enr0, vecs[i].rda0,
                   vecs[i].rda1, vecs[i].bus_sel, vecs[i].alu_op, vecs[i].latch,
                   vecs[i].busy, vecs[i].done, vecs[i].ill, vecs[i].cnt};
            chk(vecs[i].name, 32'(act), 32'(exp));
        end

        // EXEC held high through an ADD; INSTR changes after acceptance
        enw_seen  = 0;
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h08D;
        tick();
        chk("hold_t1_latch", 32'(bus.ALU_LATCH), 32'd1);
        enw_seen += int'(bus.ENW);
        bus.INSTR = 10'h010;
        tick();
        chk("hold_t2_wra", 32'(bus.WRA), 32'd1);
        enw_seen += int'(bus.ENW);
        tick();
        chk("hold_fin_done", 32'(bus.DONE), 32'd1);
        enw_seen += int'(bus.ENW);
        tick();
        chk("hold_idle_busy", 32'(bus.BUSY), 32'd0);
        enw_seen += int'(bus.ENW);
        chk("hold_one_write", 32'(enw_seen), 32'd1);
        tick();
        chk("hold_second_t1", 32'({bus.BUSY, bus.ENW, bus.WRA}), 32'b1_1_010);
        bus.EXEC = 1'b0;
        tick();
        tick();
        chk("hold_cnt", 32'(bus.INSTR_CNT), 32'd8);

        // Reset during T1 of SUB R4,R6
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h0E6;
        tick();
        bus.EXEC = 1'b0;
        chk("rst_sub_t1_latch", 32'(bus.ALU_LATCH), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_sub_forced", 32'({bus.ENW, bus.ALU_LATCH}), 32'd0);
        tick();
        rst = 1'b0;
        chk("rst_sub_after", 32'({bus.BUSY, bus.ENW, bus.DONE, bus.INSTR_CNT}), 32'd0);

        // Reset during T2 of ADD must suppress the write strobe
        bus.EXEC  = 1'b1;
        bus.INSTR = 10'h08D;
        tick();
        bus.EXEC = 1'b0;
        tick();
        chk("rst_add_t2_enw", 32'(bus.ENW), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_add_forced", 32'(bus.ENW), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_add_after", 32'({bus.BUSY, bus.DONE, bus.INSTR_CNT}), 32'd0);

        // 256 LOADs wrap the counter back to zero
        for (int n = 0; n < 255; n++) begin
            run_load();
        end
        chk("wrap_255", 32'(bus.INSTR_CNT), 32'd255);
        run_load();
        chk("wrap_0", 32'(bus.INSTR_CNT), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
